sys_vga_ram_arbiter: RTL and testbench
======================================

SYS_VGA_RAM_ARBITER -- requirements
Module: sys_vga_ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, default 11, word address width (2048 words).
- DATA_W, default 32, data width; byteenable width is DATA_W/8.
- MAX_WAIT, default 8, starvation limit for m1 in cycles.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  word address for display-fetch master (m0) and CPU master (m1).
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes for a write.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_urgent  in  1  display line buffer below threshold.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle.
- ram_address  out  ADDR_W  shared RAM port address.
- ram_byteenable  out  DATA_W/8  shared RAM port byte lanes.
- ram_chipselect  out  1  shared RAM port select.
- ram_write  out  1  shared RAM port write strobe.
- ram_writedata  out  DATA_W  shared RAM port write data.
- ram_clken  out  1  RAM clock enable, tied to 1.
- ram_readdata  in  DATA_W  RAM read data, valid the cycle after the address is accepted.

Function
REQ-003 A master requests when its read or write is high; simultaneous read and write from one master SHALL be treated as a write.
REQ-004 At most one master SHALL be granted per cycle; the grant is combinational in the same cycle.
REQ-005 mX_waitrequest SHALL equal request_X AND NOT grant_X; it SHALL be 0 when the master is idle.
REQ-006 Grant priority SHALL be, in order: m1 if starve_cnt == MAX_WAIT; else m0 if m0_urgent and m0 requests; else round-robin between requesters, favouring the master not in last_grant; else the sole requester.
REQ-007 ram_chipselect SHALL equal "any grant".
REQ-008 ram_address, ram_byteenable, ram_write and ram_writedata SHALL be muxed from the granted master.
REQ-009 When no master is granted, ram_write and ram_byteenable SHALL be 0.
REQ-010 On a granted read, ram_byteenable SHALL be all ones.
REQ-011 last_grant SHALL update to the granted master on every grant and hold otherwise.
REQ-012 starve_cnt SHALL increment, saturating at MAX_WAIT, each cycle m1 requests and is not granted.
REQ-013 starve_cnt SHALL clear when m1 is granted or m1 does not request.
REQ-014 Read latency SHALL be exactly 1 cycle. A registered tag (valid, master id) is captured on each granted read. The next cycle, mX_readdatavalid is 1 for the tagged master only.
REQ-015 mX_readdata SHALL pass ram_readdata through unregistered.
REQ-016 Back-to-back reads from alternating masters SHALL sustain 1 access per cycle with no bubbles.
REQ-017 Writes SHALL produce no readdatavalid.
REQ-018 A master holding its request under waitrequest SHALL keep its address and data stable; the arbiter does not check this.

Reset
REQ-019 On reset: last_grant = m1, starve_cnt = 0, read tag invalid.
REQ-020 During reset, both readdatavalid outputs SHALL be 0, ram_chipselect SHALL be 0, and both waitrequest outputs SHALL be 1.
REQ-021 Reset asserted mid-read SHALL discard the pending tag; no readdatavalid follows reset release.

Structure
REQ-022 Package sys_vga_pkg SHALL hold ADDR_W, DATA_W and the master-id type (M0, M1).
REQ-023 One sub-module, sys_vga_arb_core, SHALL contain the grant logic, last_grant and starve_cnt. The top level holds the muxes and the read-tag pipeline.

Verification
REQ-024 m0 read at 0x010 alone -> grant cycle 0; m0_readdatavalid cycle 1 with RAM word 0x010; m1 outputs idle.
REQ-025 m0 and m1 both read continuously, urgent=0 -> grants alternate m0, m1, m0, ...; readdatavalid alternates with 1-cycle latency.
REQ-026 m0_urgent=1 with m0 and m1 requesting continuously, MAX_WAIT=8 -> m0 granted 8 cycles, m1 granted cycle 9 (starve_cnt==8), then starve_cnt=0.
REQ-027 m1 writes 0xDEADBEEF to 0x7FF with byteenable 0b0011, then m0 reads 0x7FF -> m0_readdata[15:0]=0xBEEF and upper bytes unchanged; no readdatavalid for the write.
REQ-028 Reset pulsed the cycle after an m1 read grant -> m1_readdatavalid stays 0; first post-reset tie grants m0.

Source files
------------

// File: rtl/sys_vga_pkg.sv
// Shared types and default widths for the VGA/CPU RAM arbiter.
package sys_vga_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  // Master identifiers: m0 is the display fetch, m1 is the CPU.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  // Read tag carried one cycle alongside the RAM read latency.
  typedef struct packed {
    logic       valid;
    master_id_t id;
  } read_tag_t;

endpackage

// File: rtl/sys_vga_arb_core.sv
// Grant decision for the two masters plus fairness/starvation state.
module sys_vga_arb_core
  import sys_vga_pkg::master_id_t, sys_vga_pkg::M0, sys_vga_pkg::M1;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic urgent,
  output logic gnt0,
  output logic gnt1
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  master_id_t       last_grant;
  logic [CNT_W-1:0] starve_cnt;

  // Combinational grant: starving m1 first, then urgent m0, then round-robin on a tie.
  // No grant is issued while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req1 && (starve_cnt == CNT_MAX)) begin
        gnt1 = 1'b1;
      end else if (urgent && req0) begin
        gnt0 = 1'b1;
      end else if (req0 && req1) begin
        if (last_grant == M0) gnt1 = 1'b1;
        else                  gnt0 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Track the most recent winner and how long m1 has been held off.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= M1;
      starve_cnt <= '0;
    end else begin
      if (gnt0)      last_grant <= M0;
      else if (gnt1) last_grant <= M1;

      if (req1 && !gnt1) begin
        if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sys_vga_ram_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
//
// Handshake: a master presents a request by raising read or write (both high
// counts as a write). The request is accepted in any cycle where waitrequest is
// low while the request is high; the master must hold address/data stable until
// then. For an accepted read, readdatavalid pulses exactly one cycle later with
// readdata valid in that same cycle. Writes never return readdatavalid.
module sys_vga_ram_arbiter
  import sys_vga_pkg::master_id_t, sys_vga_pkg::M0, sys_vga_pkg::M1,
         sys_vga_pkg::read_tag_t;
#(
  parameter int ADDR_W   = sys_vga_pkg::ADDR_W,
  parameter int DATA_W   = sys_vga_pkg::DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_urgent,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic      req0, req1;
  logic      gnt0, gnt1;
  read_tag_t rd_tag;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  sys_vga_arb_core #(
    .MAX_WAIT (MAX_WAIT)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .urgent (m0_urgent),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // Masters are stalled throughout reset; otherwise only a losing requester waits.
  assign m0_waitrequest = reset | (req0 & ~gnt0);
  assign m1_waitrequest = reset | (req1 & ~gnt1);

  assign ram_clken      = 1'b1;
  assign ram_chipselect = gnt0 | gnt1;

  // Route the granted master to the RAM port; lanes and strobe stay low when idle.
  always_comb begin
    ram_address    = m0_address;
    ram_writedata  = m0_writedata;
    ram_write      = 1'b0;
    ram_byteenable = '0;
    if (gnt1) begin
      ram_address    = m1_address;
      ram_writedata  = m1_writedata;
      ram_write      = m1_write;
      ram_byteenable = m1_write ? m1_byteenable : '1;
    end else if (gnt0) begin
      ram_write      = m0_write;
      ram_byteenable = m0_write ? m0_byteenable : '1;
    end
  end

  // Remember who owns the read in flight so its data is steered next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_tag.valid <= 1'b0;
      rd_tag.id    <= M1;
    end else begin
      rd_tag.valid <= (gnt0 & ~m0_write) | (gnt1 & ~m1_write);
      rd_tag.id    <= gnt1 ? M1 : M0;
    end
  end

  assign m0_readdatavalid = ~reset & rd_tag.valid & (rd_tag.id == M0);
  assign m1_readdatavalid = ~reset & rd_tag.valid & (rd_tag.id == M1);

  assign m0_readdata = ram_readdata;
  assign m1_readdata = ram_readdata;

endmodule

// File: tb/tb_sys_vga_ram_arbiter.sv
// Directed bench for sys_vga_ram_arbiter with a behavioural 1-cycle RAM.
module tb_sys_vga_ram_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write, m0_urgent;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata;

  int vectors = 0;
  int miscompares = 0;

  sys_vga_ram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_urgent        (m0_urgent),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  // ---------------- RAM model: word i initialised to 0x1000_0000 | i ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h1000_0000 | DATA_W'(i);
    ram_readdata = '0;
  end

  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < BE_W; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_urgent = 1'b0;
    m1_read = 1'b0; m1_write = 1'b0;
    m0_address = '0; m1_address = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive_idle();
    reset = 1'b1;

    // Reset held with m0 asking for a read: everything stalled and quiet.
    next_cycle();
    m0_read = 1'b1; m0_address = 11'h010;
    next_cycle();
    #2;
    chk("rst_wait0", 64'(m0_waitrequest), 64'd1);
    chk("rst_wait1", 64'(m1_waitrequest), 64'd1);
    chk("rst_cs", 64'(ram_chipselect), 64'd0);
    chk("rst_rdv0", 64'(m0_readdatavalid), 64'd0);
    chk("rst_rdv1", 64'(m1_readdatavalid), 64'd0);
    chk("rst_clken", 64'(ram_clken), 64'd1);

    // Single m0 read of 0x010.
    next_cycle();
    reset = 1'b0;
    #2;
    chk("rd0_cs", 64'(ram_chipselect), 64'd1);
    chk("rd0_addr", 64'(ram_address), 64'h010);
    chk("rd0_be", 64'(ram_byteenable), 64'hF);
    chk("rd0_wr", 64'(ram_write), 64'd0);
    chk("rd0_wait0", 64'(m0_waitrequest), 64'd0);
    chk("rd0_wait1_idle", 64'(m1_waitrequest), 64'd0);
    next_cycle();
    drive_idle();
    #2;
    chk("rd0_rdv0", 64'(m0_readdatavalid), 64'd1);
    chk("rd0_data", 64'(m0_readdata), 64'h1000_0010);
    chk("rd0_rdv1", 64'(m1_readdatavalid), 64'd0);
    chk("idle_cs", 64'(ram_chipselect), 64'd0);
    chk("idle_be", 64'(ram_byteenable), 64'h0);
    chk("idle_wr", 64'(ram_write), 64'd0);

    // Both masters reading continuously; last winner was m0 so m1 goes first.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      m0_read = 1'b1; m0_address = 11'h020;
      m1_read = 1'b1; m1_address = 11'h030;
      #2;
      chk("rr_wait0", 64'(m0_waitrequest), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_wait1", 64'(m1_waitrequest), (i % 2 == 0) ? 64'd0 : 64'd1);
      chk("rr_addr", 64'(ram_address), (i % 2 == 0) ? 64'h030 : 64'h020);
      if (i > 0) begin
        chk("rr_rdv0", 64'(m0_readdatavalid), (i % 2 == 0) ? 64'd1 : 64'd0);
        chk("rr_rdv1", 64'(m1_readdatavalid), (i % 2 == 0) ? 64'd0 : 64'd1);
        chk("rr_data", 64'(ram_readdata), (i % 2 == 0) ? 64'h1000_0020 : 64'h1000_0030);
      end
    end
    next_cycle();
    drive_idle();
    #2;
    chk("rr_tail_rdv0", 64'(m0_readdatavalid), 64'd1);
    chk("rr_tail_data", 64'(m0_readdata), 64'h1000_0020);

    // Urgent m0 against a continuously requesting m1: m1 wins on the 9th cycle.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      m0_urgent = 1'b1;
      m0_read = 1'b1; m0_address = 11'h050;
      m1_read = 1'b1; m1_address = 11'h060;
      #2;
      chk("urg_wait0", 64'(m0_waitrequest), (i == 8) ? 64'd1 : 64'd0);
      chk("urg_wait1", 64'(m1_waitrequest), (i == 8) ? 64'd0 : 64'd1);
      chk("urg_addr", 64'(ram_address), (i == 8) ? 64'h060 : 64'h050);
    end
    next_cycle();
    drive_idle();
    #2;
    chk("urg_tail_rdv0", 64'(m0_readdatavalid), 64'd1);
    chk("urg_tail_data", 64'(m0_readdata), 64'h1000_0050);

    // m1 partial write (read+write together counts as write), then m0 reads it back.
    next_cycle();
    m1_read = 1'b1; m1_write = 1'b1;
    m1_address = 11'h7FF; m1_byteenable = 4'b0011; m1_writedata = 32'hDEAD_BEEF;
    #2;
    chk("wr_cs", 64'(ram_chipselect), 64'd1);
    chk("wr_strobe", 64'(ram_write), 64'd1);
    chk("wr_be", 64'(ram_byteenable), 64'h3);
    chk("wr_data", 64'(ram_writedata), 64'hDEAD_BEEF);
    chk("wr_addr", 64'(ram_address), 64'h7FF);
    next_cycle();
    drive_idle();
    m0_read = 1'b1; m0_address = 11'h7FF;
    #2;
    chk("wr_no_rdv1", 64'(m1_readdatavalid), 64'd0);
    chk("wr_no_rdv0", 64'(m0_readdatavalid), 64'd0);
    chk("wb_wait0", 64'(m0_waitrequest), 64'd0);
    next_cycle();
    drive_idle();
    #2;
    chk("wb_rdv0", 64'(m0_readdatavalid), 64'd1);
    chk("wb_data", 64'(m0_readdata), 64'h1000_BEEF);

    // m1 read granted, then reset next cycle: its data must never be flagged valid.
    next_cycle();
    m1_read = 1'b1; m1_address = 11'h040;
    #2;
    chk("rr1_wait1", 64'(m1_waitrequest), 64'd0);
    next_cycle();
    drive_idle();
    reset = 1'b1;
    #2;
    chk("mid_rst_rdv1", 64'(m1_readdatavalid), 64'd0);
    chk("mid_rst_cs", 64'(ram_chipselect), 64'd0);
    next_cycle();
    reset = 1'b0;
    #2;
    chk("post_rst_rdv1", 64'(m1_readdatavalid), 64'd0);
    chk("post_rst_rdv0", 64'(m0_readdatavalid), 64'd0);
    next_cycle();
    m0_read = 1'b1; m0_address = 11'h011;
    m1_read = 1'b1; m1_address = 11'h012;
    #2;
    chk("tie_wait0", 64'(m0_waitrequest), 64'd0);
    chk("tie_wait1", 64'(m1_waitrequest), 64'd1);
    chk("tie_addr", 64'(ram_address), 64'h011);
    next_cycle();
    drive_idle();
    #2;
    chk("tie_rdv0", 64'(m0_readdatavalid), 64'd1);
    chk("tie_data", 64'(m0_readdata), 64'h1000_0011);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
